// File: rtl/uart_time_cmd_parser_pkg.sv
// uart_cmd_pkg: shared definitions for the UART time-set command parser.
// Holds the ASCII constants recognised or produced by the parser, the parser
// state encoding, the default idle-byte timeout and a small end-of-line helper.
package uart_cmd_pkg;

    localparam logic [7:0] ASCII_T     = 8'h54;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_K     = 8'h4B;
    localparam logic [7:0] ASCII_E     = 8'h45;

    // One second at 100 MHz.
    localparam int TIMEOUT_CYCLES_DEFAULT = 100_000_000;

    typedef enum logic [3:0] {
        IDLE,
        H10,
        H1,
        C1,
        M10,
        M1,
        C2,
        S10,
        S1,
        TERM,
        FLUSH,
        ACK
    } state_e;

    function automatic logic is_eol(input logic [7:0] b);
        return (b == ASCII_CR) || (b == ASCII_LF);
    endfunction

endpackage

// File: rtl/uart_time_cmd_parser_ascii_digit_check.sv
// ascii_digit_check: combinational ASCII decimal digit classifier.
// Ports:
//   data_i     - candidate ASCII byte
//   max_i      - largest digit value accepted for the current field
//   is_digit_o - byte is '0'..'9'
//   in_range_o - byte is a digit and its value is <= max_i
//   value_o    - BCD value of the byte (meaningful only when is_digit_o)
module ascii_digit_check
    import uart_cmd_pkg::*;
(
    input  logic [7:0] data_i,
    input  logic [3:0] max_i,
    output logic       is_digit_o,
    output logic       in_range_o,
    output logic [3:0] value_o
);

    assign is_digit_o = (data_i >= ASCII_0) && (data_i <= (ASCII_0 + 8'd9));
    // '0'..'9' are 0x30..0x39, so the low nibble already is the digit value.
    assign value_o    = data_i[3:0];
    assign in_range_o = is_digit_o && (value_o <= max_i);

endmodule

// File: rtl/uart_time_cmd_parser.sv
// uart_time_cmd_parser: pops ASCII bytes from the UART RX FIFO, recognises the
// time-set frame "T HH:MM:SS <CR|LF>", range-checks every field and, on a valid
// frame, loads six BCD digits with a one-cycle strobe. Every frame (good, bad
// or timed out) is answered with a single 'K' or 'E' byte pushed to the TX FIFO.
// Ports:
//   iClk, iRst             - clock, asynchronous active-high reset
//   iRx_Empty, iRx_Data    - RX FIFO status and first-word-fall-through head
//   oRx_Pop                - consumes iRx_Data in the current cycle
//   iTx_Full               - TX FIFO full
//   oTx_Push, oTx_Data     - acknowledge byte push
//   oLoad                  - one-cycle strobe, new digits valid from this cycle
//   oHour_10..oSec_1       - BCD time of the last valid frame
//   oErr                   - set by a rejected frame, cleared by the next load
module uart_time_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iRx_Empty,
    input  logic [7:0] iRx_Data,
    output logic       oRx_Pop,
    input  logic       iTx_Full,
    output logic       oTx_Push,
    output logic [7:0] oTx_Data,
    output logic       oLoad,
    output logic [3:0] oHour_10,
    output logic [3:0] oHour_1,
    output logic [3:0] oMin_10,
    output logic [3:0] oMin_1,
    output logic [3:0] oSec_10,
    output logic [3:0] oSec_1,
    output logic       oErr
);

    localparam int               CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q;
    logic             pop_q;
    logic [CNT_W-1:0] cnt_q;
    // Shadow digits: filled while parsing, copied out only on a valid terminator.
    logic [3:0]       sh_h10_q, sh_h1_q, sh_m10_q, sh_m1_q, sh_s10_q, sh_s1_q;
    logic [3:0]       hour10_q, hour1_q, min10_q, min1_q, sec10_q, sec1_q;
    logic             load_q;
    logic             err_q;
    logic [7:0]       ack_q;

    logic             rx_pop_d;
    logic             eol_d;
    logic             is_digit_d;
    logic             in_range_d;
    logic             field_ok_d;
    logic [3:0]       digit_max_d;
    logic [3:0]       digit_val_d;
    state_e           parse_next_d;

    // Pops are suppressed in the cycle after a pop so the FIFO head has a cycle
    // to advance; ACK never pops so bytes behind the frame wait in the FIFO.
    assign rx_pop_d = (state_q != ACK) && !iRx_Empty && !pop_q;
    assign eol_d    = is_eol(iRx_Data);

    always_comb begin
        digit_max_d = 4'd9;
        case (state_q)
            H10:      digit_max_d = 4'd2;
            H1:       digit_max_d = (sh_h10_q == 4'd2) ? 4'd3 : 4'd9;
            M10, S10: digit_max_d = 4'd5;
            default:  digit_max_d = 4'd9;
        endcase
    end

    ascii_digit_check u_digit (
        .data_i     (iRx_Data),
        .max_i      (digit_max_d),
        .is_digit_o (is_digit_d),
        .in_range_o (in_range_d),
        .value_o    (digit_val_d)
    );

    always_comb begin
        field_ok_d   = 1'b0;
        parse_next_d = state_q;
        case (state_q)
            H10:     begin field_ok_d = is_digit_d && in_range_d;  parse_next_d = H1;   end
            H1:      begin field_ok_d = is_digit_d && in_range_d;  parse_next_d = C1;   end
            C1:      begin field_ok_d = (iRx_Data == ASCII_COLON); parse_next_d = M10;  end
            M10:     begin field_ok_d = is_digit_d && in_range_d;  parse_next_d = M1;   end
            M1:      begin field_ok_d = is_digit_d && in_range_d;  parse_next_d = C2;   end
            C2:      begin field_ok_d = (iRx_Data == ASCII_COLON); parse_next_d = S10;  end
            S10:     begin field_ok_d = is_digit_d && in_range_d;  parse_next_d = S1;   end
            S1:      begin field_ok_d = is_digit_d && in_range_d;  parse_next_d = TERM; end
            TERM:    begin field_ok_d = eol_d;                     parse_next_d = ACK;  end
            default: begin field_ok_d = 1'b0;                      parse_next_d = state_q; end
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q  <= IDLE;
            pop_q    <= 1'b0;
            cnt_q    <= '0;
            sh_h10_q <= '0;
            sh_h1_q  <= '0;
            sh_m10_q <= '0;
            sh_m1_q  <= '0;
            sh_s10_q <= '0;
            sh_s1_q  <= '0;
            hour10_q <= '0;
            hour1_q  <= '0;
            min10_q  <= '0;
            min1_q   <= '0;
            sec10_q  <= '0;
            sec1_q   <= '0;
            load_q   <= 1'b0;
            err_q    <= 1'b0;
            ack_q    <= '0;
        end else begin
            pop_q  <= rx_pop_d;
            load_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (rx_pop_d && (iRx_Data == ASCII_T)) begin
                        state_q <= H10;
                    end
                end
                ACK: begin
                    cnt_q <= '0;
                    if (!iTx_Full) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    // H10..TERM and FLUSH: byte handling plus idle-byte timeout.
                    if (rx_pop_d) begin
                        cnt_q <= '0;
                        if (state_q == FLUSH) begin
                            if (eol_d) begin
                                state_q <= ACK;
                                err_q   <= 1'b1;
                                ack_q   <= ASCII_E;
                            end
                        end else if (field_ok_d) begin
                            state_q <= parse_next_d;
                            case (state_q)
                                H10: sh_h10_q <= digit_val_d;
                                H1:  sh_h1_q  <= digit_val_d;
                                M10: sh_m10_q <= digit_val_d;
                                M1:  sh_m1_q  <= digit_val_d;
                                S10: sh_s10_q <= digit_val_d;
                                S1:  sh_s1_q  <= digit_val_d;
                                TERM: begin
                                    hour10_q <= sh_h10_q;
                                    hour1_q  <= sh_h1_q;
                                    min10_q  <= sh_m10_q;
                                    min1_q   <= sh_m1_q;
                                    sec10_q  <= sh_s10_q;
                                    sec1_q   <= sh_s1_q;
                                    load_q   <= 1'b1;
                                    err_q    <= 1'b0;
                                    ack_q    <= ASCII_K;
                                end
                                default: ;
                            endcase
                        end else if (eol_d) begin
                            // A premature terminator already ends the frame.
                            state_q <= ACK;
                            err_q   <= 1'b1;
                            ack_q   <= ASCII_E;
                        end else begin
                            state_q <= FLUSH;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ACK;
                        err_q   <= 1'b1;
                        ack_q   <= ASCII_E;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign oRx_Pop  = rx_pop_d;
    assign oTx_Push = (state_q == ACK) && !iTx_Full;
    assign oTx_Data = ack_q;
    assign oLoad    = load_q;
    assign oErr     = err_q;
    assign oHour_10 = hour10_q;
    assign oHour_1  = hour1_q;
    assign oMin_10  = min10_q;
    assign oMin_1   = min1_q;
    assign oSec_10  = sec10_q;
    assign oSec_1   = sec1_q;

endmodule

// File: doc/uart_time_cmd_parser.md
# uart_time_cmd_parser

Receive-side command parser for the digital clock's UART link: pops ASCII bytes from the UART RX FIFO and recognises the PC time-set frame `T HH:MM:SS <CR|LF>`. Each field is range-checked. A valid frame produces parallel BCD digits plus a one-cycle load strobe for the clock core. Every frame is answered with a one-byte acknowledge ('K' or 'E') pushed into the TX FIFO. It is the inverse of the time-to-ASCII encode/transmit path.

## Interface
Parameters:
- TIMEOUT_CYCLES, 100_000_000 — idle-byte limit inside a frame (1 s at 100 MHz).

Ports:
- iClk  in  1  system clock.
- iRst  in  1  reset, asynchronous, active-high.
- iRx_Empty  in  1  RX FIFO empty.
- iRx_Data  in  8  RX FIFO head byte, first-word-fall-through, valid when !iRx_Empty.
- oRx_Pop  out  1  one-cycle pop; consumes iRx_Data in that cycle.
- iTx_Full  in  1  TX FIFO full.
- oTx_Push  out  1  one-cycle push of oTx_Data.
- oTx_Data  out  8  ack byte: 0x4B 'K' or 0x45 'E'.
- oLoad  out  1  one-cycle strobe; digits valid from this cycle on.
- oHour_10, oHour_1, oMin_10, oMin_1, oSec_10, oSec_1  out  4 each  BCD time.
- oErr  out  1  sticky since last valid load; cleared by the next oLoad.

## Operation
- Reset values: all outputs 0; state IDLE; timeout counter 0.
- Pop rule: oRx_Pop = !iRx_Empty in every state that consumes bytes (IDLE…TERM, FLUSH), and only if oRx_Pop was low in the previous cycle. This gives at most one pop per 2 cycles.
- Digit test: a byte is a digit if it is 0x30–0x39; value = byte − 0x30, 4 bits.
- States and acceptance:
  - IDLE: only 'T' (0x54) goes to H10; any other byte is dropped.
  - H10: digit 0–2.
  - H1: if H10 == 2, digit 0–3; otherwise 0–9.
  - C1: ':' (0x3A).
  - M10: 0–5.
  - M1: 0–9.
  - C2: ':'.
  - S10: 0–5.
  - S1: 0–9.
  - TERM: 0x0D or 0x0A.
- Shadow registers hold the digits during parsing. Outputs are updated only on valid completion, so a bad frame never corrupts the oHour…oSec values.
- Any unexpected byte in H10..TERM → FLUSH, ack = 'E'.
  - If that byte is itself CR/LF → ACK directly.
- FLUSH: discard bytes until CR/LF, then → ACK.
- Valid TERM byte: next cycle, shadow copies to outputs, oLoad = 1, oErr = 0, ack = 'K', state ACK.
- Error path into ACK: oErr = 1, digits unchanged.
- ACK: no pops. oTx_Push = !iTx_Full (combinational on iTx_Full), oTx_Data = ack byte. After the push cycle → IDLE. While iTx_Full stays high, wait indefinitely.
- Timeout: counter clears on every pop and counts in H10..TERM and FLUSH. Reaching TIMEOUT_CYCLES−1 → ACK with 'E', oErr = 1.

## Timing
- TERM byte popped in cycle N → oLoad and new digits in N+1; oTx_Push in N+1 if !iTx_Full.
- Fastest full frame (10 bytes already queued): last pop at cycle 18 relative to the first pop at cycle 0; load at 19.
- Reset mid-frame: abort immediately. No load, no ack, digits return to 0.
- A second 'T' inside a frame is an error (not a restart).
- Bytes arriving during ACK remain in the RX FIFO and are parsed after return to IDLE.

## Structure
- Package uart_cmd_pkg:
  - ASCII constants: 'T', ':', CR, LF, '0', 'K', 'E'.
  - State enum: IDLE, H10, H1, C1, M10, M1, C2, S10, S1, TERM, FLUSH, ACK.
  - Default TIMEOUT_CYCLES.
- One sub-module, ascii_digit_check (combinational): inputs are the byte and a max value; outputs are is_digit, in_range and the BCD value. It is instantiated once and driven by a per-state max.
- The timeout counter and FSM stay in the top of the block.

## Test plan
- "T12:34:56\r" queued, TX not full → oLoad once with digits 1,2,3,4,5,6; push 0x4B; oErr = 0.
- "T24:00:00\n" → no oLoad; digits keep their previous values; oErr = 1; push 0x45 once only after the LF.
- "xyT23:59:59\n" → leading bytes ignored; load 2,3,5,9,5,9; 'K'.
- "T12:3" then no byte for TIMEOUT_CYCLES (bench override: 1000) → 'E' pushed at timeout; the next "T00:00:00\r" loads all zeros.
- Valid frame with iTx_Full held high 50 cycles → oLoad at N+1; oTx_Push waits until iTx_Full falls; no pops during the wait.
- iRst asserted after "T12:" → all outputs 0 immediately, no push; subsequent valid frame parses normally.
